// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the Wishbone CLINT slice:
//   - register offsets within the CLINT window (addr[7:0], word aligned)
//   - bus FSM state encoding
//   - mtimecmp reset value
//   - byte_merge(): applies a 4-bit byte-enable mask to a 32-bit word
// -----------------------------------------------------------------------------
package clint_pkg;

   localparam int WB_AD_WIDTH = 32;

   localparam logic [7:0] CLINT_MSIP        = 8'h00;
   localparam logic [7:0] CLINT_MTIMECMP_LO = 8'h08;
   localparam logic [7:0] CLINT_MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] CLINT_MTIME_LO    = 8'h10;
   localparam logic [7:0] CLINT_MTIME_HI    = 8'h14;
   localparam logic [7:0] CLINT_PRESC       = 8'h18;

   // All-ones keeps the timer interrupt quiet until software programs it.
   localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_ACK  = 2'd1,
      BUS_WAIT = 2'd2
   } bus_state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_clint_if.sv
// -----------------------------------------------------------------------------
// wb_clint_if
// Wishbone classic single-transfer signals between the interconnect's CLINT
// port (master side) and wb_clint (slave side).
//   wbm_clint_cyc_i/stb_i/we_i   : cycle, strobe, write enable
//   wbm_clint_addr_i [AW]         : byte address
//   wbm_clint_wdata_i[DW]         : write data
//   wbm_clint_sel_i  [DW/8]       : byte enables
//   clint_wbm_rdata_o[DW]         : read data
//   clint_wbm_ack_o               : transfer acknowledge
// -----------------------------------------------------------------------------
interface wb_clint_if
   import clint_pkg::*;
#(
   parameter int AW = WB_AD_WIDTH,
   parameter int DW = 32
);
   logic            wbm_clint_cyc_i;
   logic            wbm_clint_stb_i;
   logic            wbm_clint_we_i;
   logic [AW-1:0]   wbm_clint_addr_i;
   logic [DW-1:0]   wbm_clint_wdata_i;
   logic [DW/8-1:0] wbm_clint_sel_i;
   logic [DW-1:0]   clint_wbm_rdata_o;
   logic            clint_wbm_ack_o;

   modport master (
      output wbm_clint_cyc_i, wbm_clint_stb_i, wbm_clint_we_i,
             wbm_clint_addr_i, wbm_clint_wdata_i, wbm_clint_sel_i,
      input  clint_wbm_rdata_o, clint_wbm_ack_o
   );

   modport slave (
      input  wbm_clint_cyc_i, wbm_clint_stb_i, wbm_clint_we_i,
             wbm_clint_addr_i, wbm_clint_wdata_i, wbm_clint_sel_i,
      output clint_wbm_rdata_o, clint_wbm_ack_o
   );
endinterface

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Prescaled 64-bit mtime counter with a byte-masked write port and the
// registered machine-timer compare.
//   clk, rst        : clock, synchronous active-high reset
//   presc           : prescaler terminal count (tick every presc+1 cycles)
//   presc_wr        : presc is being written this cycle; restarts tick_cnt
//   lo_wr, hi_wr    : write mtime[31:0] / mtime[63:32] this cycle
//   wdata, sel      : write data and byte enables for the mtime write
//   mtimecmp        : current compare value
//   mtime           : counter value
//   timer_irq       : registered (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module clint_timer
   import clint_pkg::*;
#(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PRESC_W-1:0] presc,
   input  logic               presc_wr,
   input  logic               lo_wr,
   input  logic               hi_wr,
   input  logic [31:0]        wdata,
   input  logic [3:0]         sel,
   input  logic [63:0]        mtimecmp,
   output logic [63:0]        mtime,
   output logic               timer_irq
);

   logic [PRESC_W-1:0] tick_cnt;
   logic               tick;
   logic [63:0]        mtime_next;

   assign tick = (tick_cnt == presc);

   // A software write to either half wins over the increment for the whole
   // 64-bit word, so the value just written is exactly what software reads.
   always_comb begin
      // NOTE: default assignment first so no path leaves mtime_next unassigned (no latch).
      mtime_next = mtime;
      if (lo_wr || hi_wr) begin
         if (lo_wr) mtime_next[31:0]  = byte_merge(mtime[31:0],  wdata, sel);
         if (hi_wr) mtime_next[63:32] = byte_merge(mtime[63:32], wdata, sel);
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         mtime     <= '0;
         timer_irq <= 1'b0;
      end else begin
         tick_cnt  <= (presc_wr || tick) ? '0 : tick_cnt + PRESC_W'(1);
         mtime     <= mtime_next;
         // Compares the registered values, so the interrupt lags by one cycle.
         timer_irq <= (mtime >= mtimecmp);
      end
   end

endmodule

// File: rtl/wb_clint.sv
// -----------------------------------------------------------------------------
// wb_clint
// Machine-level core-local interruptor on the peripheral Wishbone bus.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : Wishbone slave (wb_clint_if.slave), one registered ack per
//                 strobe
//   timer_irq_o : machine timer interrupt (MTIP)
//   soft_irq_o  : machine software interrupt (MSIP)
// Register map (addr[7:0]): 0x00 msip, 0x08/0x0C mtimecmp lo/hi,
// 0x10/0x14 mtime lo/hi, 0x18 presc. Other offsets read 0, ignore writes.
// -----------------------------------------------------------------------------
module wb_clint
   import clint_pkg::*;
#(
   parameter int         AW         = WB_AD_WIDTH,
   parameter int         DW         = 32,
   parameter logic [3:0] SEL_NIBBLE = 4'h5,
   parameter int         PRESC_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   wb_clint_if.slave   bus,
   output logic        timer_irq_o,
   output logic        soft_irq_o
);

   bus_state_e         state;
   logic               ack_q;
   logic [DW-1:0]      rdata_q;

   logic [AW-1:0]      addr;
   logic [7:0]         off;
   logic [31:0]        wdata;
   logic [3:0]         sel;
   logic               req;
   logic               commit;
   logic               wr;

   logic               msip;
   logic [63:0]        mtimecmp;
   logic [PRESC_W-1:0] presc;
   logic [31:0]        presc_merged;
   logic [63:0]        mtime;
   logic [31:0]        rd_mux;
   logic               unused_bits;

   assign addr  = bus.wbm_clint_addr_i;
   assign off   = addr[7:0];
   assign wdata = bus.wbm_clint_wdata_i;
   assign sel   = bus.wbm_clint_sel_i;

   // cyc/stb are broadcast by the interconnect; only our nibble is a request.
   assign req    = bus.wbm_clint_cyc_i & bus.wbm_clint_stb_i & (addr[11:8] == SEL_NIBBLE);
   assign commit = (state == BUS_IDLE) & req;
   assign wr     = commit & bus.wbm_clint_we_i;

   assign presc_merged = byte_merge(32'(presc), wdata, sel);
   assign unused_bits  = ^{addr[AW-1:12], presc_merged[31:PRESC_W]};

   clint_timer #(.PRESC_W(PRESC_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .presc     (presc),
      .presc_wr  (wr && off == CLINT_PRESC),
      .lo_wr     (wr && off == CLINT_MTIME_LO),
      .hi_wr     (wr && off == CLINT_MTIME_HI),
      .wdata     (wdata),
      .sel       (sel),
      .mtimecmp  (mtimecmp),
      .mtime     (mtime),
      .timer_irq (timer_irq_o)
   );

   always_comb begin
      rd_mux = '0;
      case (off)
         CLINT_MSIP:        rd_mux = {31'd0, msip};
         CLINT_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         CLINT_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         CLINT_MTIME_LO:    rd_mux = mtime[31:0];
         CLINT_MTIME_HI:    rd_mux = mtime[63:32];
         CLINT_PRESC:       rd_mux = 32'(presc);
         default:           rd_mux = '0;
      endcase
   end

   // Bus FSM: WAIT holds off a second ack until the master drops stb or cyc.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= BUS_IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state)
            BUS_IDLE: begin
               if (req) begin
                  state <= BUS_ACK;
                  ack_q <= 1'b1;
                  if (!bus.wbm_clint_we_i) rdata_q <= DW'(rd_mux);
               end
            end
            BUS_ACK: begin
               state <= BUS_WAIT;
               ack_q <= 1'b0;
            end
            BUS_WAIT: begin
               if (!bus.wbm_clint_stb_i || !bus.wbm_clint_cyc_i) state <= BUS_IDLE;
            end
            default: begin
               state <= BUS_IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         msip       <= 1'b0;
         mtimecmp   <= CLINT_MTIMECMP_RST;
         presc      <= '0;
         soft_irq_o <= 1'b0;
      end else begin
         soft_irq_o <= msip;
         if (wr && off == CLINT_MSIP && sel[0]) msip <= wdata[0];
         if (wr && off == CLINT_MTIMECMP_LO) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0],  wdata, sel);
         if (wr && off == CLINT_MTIMECMP_HI) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wdata, sel);
         if (wr && off == CLINT_PRESC)       presc <= presc_merged[PRESC_W-1:0];
      end
   end

   assign bus.clint_wbm_ack_o   = ack_q;
   assign bus.clint_wbm_rdata_o = rdata_q;

endmodule

// File: tb/tb_wb_clint.sv
// -----------------------------------------------------------------------------
// tb_wb_clint
// Self-checking bench for wb_clint. A transaction-level model tracks the
// register file, the prescaled mtime and both interrupt lines; every bus
// access is posted to the model at the edge it commits.
// -----------------------------------------------------------------------------
module tb_wb_clint;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic timer_irq, soft_irq;

   always #5 clk = ~clk;

   wb_clint_if #(.AW(32), .DW(32)) bus ();

   wb_clint dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .timer_irq_o (timer_irq),
      .soft_irq_o  (soft_irq)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_irq, m_soft;
   logic [15:0] m_presc, m_tick;
   logic [31:0] m_rd;

   bit          pend_v = 1'b0;
   logic        pend_we;
   logic [7:0]  pend_off;
   logic [31:0] pend_data;
   logic [3:0]  pend_sel;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      case (off)
         8'h00:   return {31'd0, m_msip};
         8'h08:   return m_cmp[31:0];
         8'h0C:   return m_cmp[63:32];
         8'h10:   return m_mtime[31:0];
         8'h14:   return m_mtime[63:32];
         8'h18:   return {16'd0, m_presc};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic        tick_m, presc_clr;
      logic [63:0] nt;
      logic [31:0] tmp;
      if (rst) begin
         m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_presc = '0; m_tick = '0;
         m_irq = 1'b0; m_soft = 1'b0; pend_v = 1'b0;
      end else begin
         m_irq  = (m_mtime >= m_cmp);
         m_soft = m_msip;
         tick_m = (m_tick == m_presc);
         nt = tick_m ? m_mtime + 64'd1 : m_mtime;
         presc_clr = 1'b0;
         if (pend_v) begin
            pend_v = 1'b0;
            if (!pend_we) m_rd = model_read(pend_off);
            else begin
               case (pend_off)
                  8'h00: if (pend_sel[0]) m_msip = pend_data[0];
                  8'h08: m_cmp[31:0]  = merge(m_cmp[31:0],  pend_data, pend_sel);
                  8'h0C: m_cmp[63:32] = merge(m_cmp[63:32], pend_data, pend_sel);
                  8'h10: nt = {m_mtime[63:32], merge(m_mtime[31:0], pend_data, pend_sel)};
                  8'h14: nt = {merge(m_mtime[63:32], pend_data, pend_sel), m_mtime[31:0]};
                  8'h18: begin
                     tmp = merge({16'd0, m_presc}, pend_data, pend_sel);
                     m_presc = tmp[15:0];
                     presc_clr = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         m_tick  = (presc_clr || tick_m) ? 16'd0 : m_tick + 16'd1;
         m_mtime = nt;
      end
   end

   // ---------------- bus driver ----------------
   // Drives one access on a negedge; the next posedge is its commit edge.
   // hold>0 keeps stb high for that many cycles; hold=0 drops it at the ack.
   task automatic bus_xfer(input logic we, input logic [3:0] nib, input logic [7:0] off,
                           input logic [31:0] data, input logic [3:0] sel, input int hold,
                           output logic [31:0] rd, output int n_ack, output int first_ack,
                           output logic [63:0] mt_at_ack);
      @(negedge clk);
      bus.wbm_clint_cyc_i   = 1'b1;
      bus.wbm_clint_stb_i   = 1'b1;
      bus.wbm_clint_we_i    = we;
      bus.wbm_clint_addr_i  = {20'd0, nib, off};
      bus.wbm_clint_wdata_i = data;
      bus.wbm_clint_sel_i   = sel;
      if (nib == 4'h5) begin
         pend_v = 1'b1; pend_we = we; pend_off = off; pend_data = data; pend_sel = sel;
      end
      n_ack = 0; first_ack = 0; rd = '0; mt_at_ack = '0;
      for (int c = 1; c <= ((hold > 0) ? hold : 8); c++) begin
         @(negedge clk);
         if (bus.clint_wbm_ack_o === 1'b1) begin
            n_ack++;
            if (first_ack == 0) begin
               first_ack = c;
               rd = bus.clint_wbm_rdata_o;
               mt_at_ack = dut.u_timer.mtime;
            end
            if (hold == 0) break;
         end
      end
      bus.wbm_clint_cyc_i = 1'b0;
      bus.wbm_clint_stb_i = 1'b0;
      bus.wbm_clint_we_i  = 1'b0;
      pend_v = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.clint_wbm_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.clint_wbm_ack_o); end
      checks++; if (bus.clint_wbm_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.clint_wbm_rdata_o); end
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_timer_irq got=%b exp=0", timer_irq); end
      checks++; if (soft_irq !== 1'b0) begin errors++; $display("FAIL reset_soft_irq got=%b exp=0", soft_irq); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      bus_xfer(1'b0, 4'h5, 8'h10, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== m_rd) begin errors++; $display("FAIL idle_mtime_lo got=%0d exp=%0d", rd, m_rd); end
      checks++; if (rd < 32'd9 || rd > 32'd11) begin errors++; $display("FAIL idle_mtime_range got=%0d exp=9..11", rd); end
      bus_xfer(1'b0, 4'h5, 8'h08, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp_lo got=%h exp=ffffffff", rd); end
      checks++; if (timer_irq !== 1'b0 || soft_irq !== 1'b0) begin errors++; $display("FAIL idle_irqs got=%b%b exp=00", timer_irq, soft_irq); end
   endtask

   task automatic test_msip();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      bus_xfer(1'b1, 4'h5, 8'h00, 32'h1, 4'hF, 0, rd, na, fa, mt);
      checks++; if (na !== 1 || fa !== 1) begin errors++; $display("FAIL msip_ack got=%0d@%0d exp=1@1", na, fa); end
      checks++; if (soft_irq !== 1'b1) begin errors++; $display("FAIL msip_soft_irq got=%b exp=1", soft_irq); end
      bus_xfer(1'b0, 4'h5, 8'h00, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL msip_read got=%h exp=1", rd); end
      bus_xfer(1'b1, 4'h5, 8'h00, 32'hFFFF_FFFF, 4'hF, 5, rd, na, fa, mt);
      checks++; if (na !== 1 || fa !== 1) begin errors++; $display("FAIL held_stb_acks got=%0d@%0d exp=1@1", na, fa); end
      bus_xfer(1'b0, 4'h5, 8'h00, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL msip_upper_bits got=%h exp=1", rd); end
      bus_xfer(1'b1, 4'h5, 8'h00, 32'h0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (soft_irq !== 1'b0) begin errors++; $display("FAIL msip_clear got=%b exp=0", soft_irq); end
   endtask

   task automatic test_prescaler();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      logic [63:0] prev_m, last_obs;
      int changes[$];
      bit risen;
      bus_xfer(1'b1, 4'h5, 8'h18, 32'd3, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h14, 32'd0, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h10, 32'd20, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h0C, 32'd0, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h08, 32'd40, 4'hF, 0, rd, na, fa, mt);
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL presc_irq_early got=%b exp=0", timer_irq); end
      risen = 1'b0;
      prev_m = m_mtime;
      last_obs = dut.u_timer.mtime;
      for (int c = 0; c < 400 && !risen; c++) begin
         @(negedge clk);
         checks++; if (dut.u_timer.mtime !== m_mtime) begin errors++; $display("FAIL presc_mtime got=%0d exp=%0d", dut.u_timer.mtime, m_mtime); end
         if (dut.u_timer.mtime != last_obs) changes.push_back(c);
         last_obs = dut.u_timer.mtime;
         if (timer_irq === 1'b1) begin
            risen = 1'b1;
            checks++; if (prev_m !== 64'd40) begin errors++; $display("FAIL irq_rise_point got_prev_mtime=%0d exp=40", prev_m); end
         end
         prev_m = m_mtime;
      end
      checks++; if (!risen) begin errors++; $display("FAIL irq_rise_timeout got=0 exp=1"); end
      checks++;
      if (changes.size() < 2 || (changes[changes.size()-1] - changes[changes.size()-2]) != 4) begin
         errors++; $display("FAIL presc_period got_changes=%0d exp_gap=4", changes.size());
      end
   endtask

   task automatic test_mtime_carry();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      bus_xfer(1'b1, 4'h5, 8'h18, 32'd0, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h14, 32'd0, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h10, 32'hFFFF_FFFF, 4'hF, 0, rd, na, fa, mt);
      checks++; if (mt !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL carry_write_hold got=%h exp=00000000ffffffff", mt); end
      checks++; if (dut.u_timer.mtime !== 64'h0000_0001_0000_0001) begin errors++; $display("FAIL carry_propagate got=%h exp=0000000100000001", dut.u_timer.mtime); end
      bus_xfer(1'b0, 4'h5, 8'h14, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL carry_read_hi got=%h exp=1", rd); end
      bus_xfer(1'b1, 4'h5, 8'h10, 32'h100, 4'hF, 0, rd, na, fa, mt);
      checks++; if (mt !== 64'h0000_0001_0000_0100) begin errors++; $display("FAIL write_beats_tick got=%h exp=0000000100000100", mt); end
      bus_xfer(1'b0, 4'h5, 8'h10, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== m_rd) begin errors++; $display("FAIL mtime_lo_after_write got=%h exp=%h", rd, m_rd); end
   endtask

   task automatic test_sel_decode();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      bus_xfer(1'b1, 4'h5, 8'h08, 32'hFFFF_FFFF, 4'hF, 0, rd, na, fa, mt);
      bus_xfer(1'b1, 4'h5, 8'h08, 32'h1234_5678, 4'b0011, 0, rd, na, fa, mt);
      bus_xfer(1'b0, 4'h5, 8'h08, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'hFFFF_5678) begin errors++; $display("FAIL sel_partial got=%h exp=ffff5678", rd); end
      bus_xfer(1'b1, 4'h3, 8'h08, 32'h0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (na !== 0) begin errors++; $display("FAIL foreign_nibble_ack got=%0d exp=0", na); end
      bus_xfer(1'b0, 4'h5, 8'h08, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'hFFFF_5678) begin errors++; $display("FAIL foreign_nibble_write got=%h exp=ffff5678", rd); end
      bus_xfer(1'b1, 4'h5, 8'h04, 32'hDEAD_BEEF, 4'hF, 0, rd, na, fa, mt);
      checks++; if (na !== 1) begin errors++; $display("FAIL unmapped_write_ack got=%0d exp=1", na); end
      bus_xfer(1'b0, 4'h5, 8'h04, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", rd); end
      bus_xfer(1'b0, 4'h5, 8'h1C, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'd0 || na !== 1) begin errors++; $display("FAIL unmapped_read_1c got=%h/%0d exp=0/1", rd, na); end
   endtask

   task automatic test_random();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      logic [7:0] offs [8] = '{8'h00, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h04, 8'h1C};
      logic [7:0] off; logic [3:0] nib; logic we; logic [31:0] data; logic [3:0] sel;
      for (int i = 0; i < 60; i++) begin
         off  = offs[$urandom_range(0, 7)];
         nib  = ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h5;
         we   = 1'($urandom_range(0, 1));
         data = (off == 8'h18) ? 32'($urandom_range(0, 5)) : $urandom;
         sel  = 4'($urandom_range(0, 15));
         bus_xfer(we, nib, off, data, sel, 0, rd, na, fa, mt);
         checks++; if (na !== ((nib == 4'h5) ? 1 : 0)) begin errors++; $display("FAIL rand_ack[%0d] got=%0d nib=%h", i, na, nib); end
         if (nib == 4'h5 && !we) begin
            checks++; if (rd !== m_rd) begin errors++; $display("FAIL rand_read[%0d] off=%h got=%h exp=%h", i, off, rd, m_rd); end
         end
         checks++; if (timer_irq !== m_irq) begin errors++; $display("FAIL rand_timer_irq[%0d] got=%b exp=%b", i, timer_irq, m_irq); end
         checks++; if (soft_irq !== m_soft) begin errors++; $display("FAIL rand_soft_irq[%0d] got=%b exp=%b", i, soft_irq, m_soft); end
      end
   endtask

   task automatic test_reset_in_ack();
      logic [31:0] rd; int na, fa; logic [63:0] mt;
      @(negedge clk);
      bus.wbm_clint_cyc_i = 1'b1; bus.wbm_clint_stb_i = 1'b1; bus.wbm_clint_we_i = 1'b1;
      bus.wbm_clint_addr_i = 32'h0000_0500; bus.wbm_clint_wdata_i = 32'h1; bus.wbm_clint_sel_i = 4'hF;
      pend_v = 1'b1; pend_we = 1'b1; pend_off = 8'h00; pend_data = 32'h1; pend_sel = 4'hF;
      @(negedge clk);
      checks++; if (bus.clint_wbm_ack_o !== 1'b1) begin errors++; $display("FAIL rst_ack_pre got=%b exp=1", bus.clint_wbm_ack_o); end
      rst = 1'b1;
      bus.wbm_clint_cyc_i = 1'b0; bus.wbm_clint_stb_i = 1'b0; bus.wbm_clint_we_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.clint_wbm_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack_drop got=%b exp=0", bus.clint_wbm_ack_o); end
      checks++; if (soft_irq !== 1'b0 || timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irqs got=%b%b exp=00", soft_irq, timer_irq); end
      rst = 1'b0;
      bus_xfer(1'b0, 4'h5, 8'h00, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_msip got=%h exp=0", rd); end
      bus_xfer(1'b0, 4'h5, 8'h0C, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mtimecmp_hi got=%h exp=ffffffff", rd); end
      bus_xfer(1'b0, 4'h5, 8'h18, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_presc got=%h exp=0", rd); end
      bus_xfer(1'b1, 4'h5, 8'h08, 32'h55, 4'hF, 0, rd, na, fa, mt);
      checks++; if (na !== 1 || fa !== 1) begin errors++; $display("FAIL post_rst_ack got=%0d@%0d exp=1@1", na, fa); end
      bus_xfer(1'b0, 4'h5, 8'h08, 32'd0, 4'hF, 0, rd, na, fa, mt);
      checks++; if (rd !== 32'h55) begin errors++; $display("FAIL post_rst_read got=%h exp=55", rd); end
   endtask

   initial begin
      bus.wbm_clint_cyc_i   = 1'b0;
      bus.wbm_clint_stb_i   = 1'b0;
      bus.wbm_clint_we_i    = 1'b0;
      bus.wbm_clint_addr_i  = '0;
      bus.wbm_clint_wdata_i = '0;
      bus.wbm_clint_sel_i   = '0;
      test_reset();
      test_msip();
      test_prescaler();
      test_mtime_carry();
      test_sel_decode();
      test_random();
      test_reset_in_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_clint.md
# wb_clint

Machine-level core-local interruptor (CLINT) on the peripheral Wishbone bus, downstream of the Wishbone interconnect's CLINT port (select nibble 0x5). Holds the 64-bit `mtime` counter with programmable prescaler, 64-bit `mtimecmp`, and `msip`. Drives the core's machine timer and software interrupt lines. Answers single Wishbone classic reads and writes with a one-cycle-registered ack.

## Interface
- `AW`, default `WB_AD_WIDTH`: Wishbone address width.
- `DW`, default 32: Wishbone data width; the register map assumes 32.
- `SEL_NIBBLE`, default 4'h5: value of addr[11:8] that selects this block.
- `PRESC_W`, default 16: prescaler width.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `wbm_clint_cyc_i` input 1: bus cycle.
- `wbm_clint_stb_i` input 1: strobe.
- `wbm_clint_we_i` input 1: write enable.
- `wbm_clint_addr_i` input AW: byte address.
- `wbm_clint_wdata_i` input DW: write data.
- `wbm_clint_sel_i` input DW/8: byte enables.
- `clint_wbm_rdata_o` output DW: read data.
- `clint_wbm_ack_o` output 1: transfer acknowledge.
- `timer_irq_o` output 1: machine timer interrupt (MTIP).
- `soft_irq_o` output 1: machine software interrupt (MSIP).

## Operation
- The interconnect broadcasts cyc/stb to all slaves. Request `req = cyc & stb & (addr[11:8]==SEL_NIBBLE)`.
- Register map on addr[7:0], word aligned:
  - 0x00 `msip`: bit 0 only; bits 31:1 read 0.
  - 0x08/0x0C `mtimecmp` lo/hi.
  - 0x10/0x14 `mtime` lo/hi.
  - 0x18 `presc`: PRESC_W bits, zero-extended.
- Unmapped offsets: read 0, writes ignored, still acked.
- Writes honour `sel` per byte. Reads ignore `sel`.
- Bus FSM states:
  - IDLE: on `req`, go to ACK. A write commits at this edge; read data is latched at this edge.
  - ACK: ack=1 for exactly one cycle; go to WAIT.
  - WAIT: ack=0; return to IDLE when `stb` or `cyc` is low.
  - This guarantees one ack per strobe even if the master holds stb.
- Prescaler:
  - `tick_cnt` counts 0..presc; at `tick_cnt==presc` it wraps to 0 and `mtime` increments by 1.
  - presc=0 means increment every cycle.
  - Writing `presc` clears `tick_cnt`.
- `mtime` is a 64-bit counter. Carry propagates lo→hi; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to mtime lo or hi in the same cycle as an increment: the written bytes take the write value, and the increment is dropped for that cycle (entire 64-bit word).
- `timer_irq_o` is registered: `mtime >= mtimecmp`, unsigned 64-bit compare on the post-update values.
- `soft_irq_o = msip[0]`, registered.
- Reset mid-transaction: FSM returns to IDLE, no ack. The master retries.

## Timing
- Reset values: ack 0, rdata 0, timer_irq 0, soft_irq 0, mtime 0, mtimecmp all-ones, msip 0, presc 0, tick_cnt 0, FSM IDLE.
- Ack latency: request seen at edge N, ack high for cycle N+1 only. The interconnect's registered slave select is valid by then.
- rdata is valid in the ack cycle and held until the next read is latched.
- Register update visible on read from the cycle after the write edge.
- Timer IRQ lags the condition by one cycle: after writing mtimecmp ≤ mtime, `timer_irq_o` rises one cycle after the write commits. Writing mtimecmp > mtime clears it with the same lag.
- `soft_irq_o` changes one cycle after the msip write commits.
- A read of mtime lo then hi is not atomic. Software re-reads hi to detect carry.

## Structure
- Package `clint_pkg` holds:
  - Offset localparams (`CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`, `CLINT_PRESC`).
  - The FSM state encoding (IDLE/ACK/WAIT).
  - The mtimecmp reset value.
- Sub-module `clint_timer`: prescaler, 64-bit mtime with byte-masked write port, increment/write priority, and the compare output register.
- Top: decode, bus FSM, register writes for msip/mtimecmp/presc, read mux.

## Test plan
- Reset, then idle 10 cycles with presc=0 → mtime reads 10±1 (account for ack cycle); timer_irq 0; soft_irq 0.
- Write 0x1 to 0x00, sel=4'hF → ack exactly one cycle after stb; soft_irq_o=1 one cycle later; read 0x00 returns 0x1. Hold stb 5 cycles → only one ack pulse.
- Write presc=3, mtimecmp hi=0, mtimecmp lo=40 → mtime increments every 4 cycles; timer_irq_o rises the cycle after mtime reaches 40.
- Write mtime lo=0xFFFF_FFFF, hi=0, presc=0 → next increment reads hi=1, lo=0. Write mtime in a tick cycle → the written value holds, with no +1 on that cycle.
- Write mtimecmp lo=0x1234_5678 with sel=4'b0011 → reads 0xFFFF_5678. Access with addr[11:8]=0x3 → no ack, no state change.
- Assert rst while in ACK → ack drops the next cycle, all registers return to reset values, and the subsequent transaction completes normally.
